// File: rtl/bus_timer_slave.sv
// Bus-mapped interval timer: CTRL/INTR/EXPR/COUNT registers, sticky expiry interrupt.
// rdy_ pulses low WAIT_STATES+1 cycles after accept; strobes are ignored until the FSM is back in IDLE.
module bus_timer_slave #(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wcnt;
  logic [3:0]  w_wcnt_nxt;
  logic        r_start;
  logic        r_periodic;
  logic        r_flag;
  logic [31:0] r_expr;
  logic [31:0] r_count;
  logic [31:0] r_rd_data;
  logic [31:0] w_rd_mux;
  logic        w_accept;
  logic        w_wr;
  logic        w_expire;
  logic        w_unused_addr;

  assign w_accept      = !cs_ && !as_ && (r_state == S_IDLE);
  assign w_wr          = w_accept && !rw;
  assign w_expire      = r_start && (r_count == r_expr);
  assign w_unused_addr = &{1'b0, addr[29:2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = S_ACK;
          end else begin
            w_state_nxt = S_WAIT;
            w_wcnt_nxt  = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_wcnt == 4'd0) w_state_nxt = S_ACK;
        else                w_wcnt_nxt  = r_wcnt - 4'd1;
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (addr[1:0])
      2'd0: w_rd_mux = {30'd0, r_periodic, r_start};
      2'd1: w_rd_mux = {31'd0, r_flag};
      2'd2: w_rd_mux = r_expr;
      2'd3: w_rd_mux = r_count;
      default: w_rd_mux = 32'd0;
    endcase
  end

  // Bus writes take priority over the counter's own updates; expiry set beats a software clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start    <= 1'b0;
      r_periodic <= 1'b0;
      r_flag     <= 1'b0;
      r_expr     <= 32'd0;
      r_count    <= 32'd0;
      r_rd_data  <= 32'd0;
    end else begin
      if (w_accept) r_rd_data <= rw ? w_rd_mux : 32'd0;

      if (w_wr && addr[1:0] == 2'd0) begin
        r_start    <= wr_data[0];
        r_periodic <= wr_data[1];
      end else if (w_expire && !r_periodic) begin
        r_start <= 1'b0;
      end

      if (w_expire)                                        r_flag <= 1'b1;
      else if (w_wr && addr[1:0] == 2'd1 && !wr_data[0])   r_flag <= 1'b0;

      if (w_wr && addr[1:0] == 2'd2) r_expr <= wr_data;

      if (w_wr && addr[1:0] == 2'd3) r_count <= wr_data;
      else if (w_expire)             r_count <= 32'd0;
      else if (r_start)              r_count <= r_count + 32'd1;
    end
  end

  assign rdy_    = (r_state != S_ACK);
  assign rd_data = (r_state == S_ACK) ? r_rd_data : 32'd0;
  assign irq     = r_flag;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed bench for bus_timer_slave: one instance with no wait states, one with three.
module tb_bus_timer_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, cs0_, as0_, rw0, rdy0_, irq0;
  logic [29:0] addr0;
  logic [31:0] wd0, rd0;
  logic        rst3_n, cs3_, as3_, rw3, rdy3_, irq3;
  logic [29:0] addr3;
  logic [31:0] wd3, rd3;

  int n_chk  = 0;
  int n_fail = 0;

  bus_timer_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0_n), .cs_(cs0_), .as_(as0_), .rw(rw0), .addr(addr0),
    .wr_data(wd0), .rd_data(rd0), .rdy_(rdy0_), .irq(irq0)
  );

  bus_timer_slave #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(rst3_n), .cs_(cs3_), .as_(as3_), .rw(rw3), .addr(addr3),
    .wr_data(wd3), .rd_data(rd3), .rdy_(rdy3_), .irq(irq3)
  );

  // One complete access; starts and returns at posedge+1, lat = cycles from accept to rdy_ low.
  task automatic bus(input bit d3, input bit r, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int lat);
    if (d3) begin cs3_ = 1'b0; as3_ = 1'b0; rw3 = r; addr3 = {28'h0, a}; wd3 = d; end
    else    begin cs0_ = 1'b0; as0_ = 1'b0; rw0 = r; addr0 = {28'h0, a}; wd0 = d; end
    @(posedge clk); #1;
    cs0_ = 1'b1; as0_ = 1'b1; cs3_ = 1'b1; as3_ = 1'b1;
    lat = 1;
    while ((d3 ? rdy3_ : rdy0_) !== 1'b0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = d3 ? rd3 : rd0;
    n_chk++;
    if (lat >= 20) begin
      n_fail++;
      $display("FAIL bus_timeout: rdy_ never fell, waited %0d cycles, required < 20", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic wr0(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    bus(1'b0, 1'b0, a, d, rd, lat);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    rst0_n = 1'b0; rst3_n = 1'b0;
    cs0_ = 1'b1; as0_ = 1'b1; rw0 = 1'b1; addr0 = '0; wd0 = '0;
    cs3_ = 1'b1; as3_ = 1'b1; rw3 = 1'b1; addr3 = '0; wd3 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (rdy0_ !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", rdy0_); end
    n_chk++; if (rd0 !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd0); end
    n_chk++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq0); end
    rst0_n = 1'b1; rst3_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 1'b1, 2'(i), 32'd0, rd, lat);
      n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_read_%0d: got %h want 0", i, rd); end
      n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL reset_lat_%0d: got %0d want 1", i, lat); end
      n_chk++;
      if (rdy0_ !== 1'b1 || rd0 !== 32'd0) begin
        n_fail++; $display("FAIL reset_post_ack_%0d: rdy_=%b rd_data=%h want 1/0", i, rdy0_, rd0);
      end
    end
  endtask

  task automatic test_periodic();
    logic [31:0] rd;
    int lat;
    int exp_seq[6] = '{1, 2, 3, 4, 0, 1};
    wr0(2'd2, 32'd4);
    wr0(2'd0, 32'h3);
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (dut0.r_count !== 32'(exp_seq[i])) begin
        n_fail++; $display("FAIL periodic_count_%0d: got %0d want %0d", i, dut0.r_count, exp_seq[i]);
      end
      n_chk++;
      if (irq0 !== (i >= 4)) begin
        n_fail++; $display("FAIL periodic_irq_%0d: got %b want %b", i, irq0, (i >= 4));
      end
      @(posedge clk); #1;
    end
    wr0(2'd0, 32'h0);
    n_chk++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL irq_sticky: got %b want 1", irq0); end
    wr0(2'd1, 32'h1);
    n_chk++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL intr_write1: got %b want 1", irq0); end
    wr0(2'd1, 32'h0);
    n_chk++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL intr_clear: got %b want 0", irq0); end
    bus(1'b0, 1'b1, 2'd1, 32'd0, rd, lat);
    n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL intr_read: got %h want 0", rd); end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    int lat;
    wr0(2'd3, 32'd0);
    wr0(2'd2, 32'd2);
    wr0(2'd0, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    bus(1'b0, 1'b1, 2'd0, 32'd0, rd, lat);
    n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL oneshot_ctrl: got %h want 0", rd); end
    bus(1'b0, 1'b1, 2'd3, 32'd0, rd, lat);
    n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL oneshot_count: got %h want 0", rd); end
    n_chk++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq: got %b want 1", irq0); end
    wr0(2'd1, 32'h0);
  endtask

  task automatic test_clear_vs_expiry();
    wr0(2'd2, 32'd3);
    wr0(2'd3, 32'd0);
    wr0(2'd0, 32'h3);
    repeat (2) @(posedge clk);
    #1;
    wr0(2'd1, 32'h0);
    n_chk++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL clear_vs_expiry_irq: got %b want 1", irq0); end
    n_chk++;
    if (dut0.r_count !== 32'd1) begin
      n_fail++; $display("FAIL clear_vs_expiry_count: got %0d want 1", dut0.r_count);
    end
    wr0(2'd0, 32'h0);
    wr0(2'd1, 32'h0);
  endtask

  task automatic test_count_write();
    logic [31:0] rd;
    int lat;
    wr0(2'd3, 32'd0);
    wr0(2'd2, 32'h20);
    wr0(2'd0, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    wr0(2'd3, 32'h10);
    bus(1'b0, 1'b1, 2'd3, 32'd0, rd, lat);
    n_chk++; if (rd !== 32'h11) begin n_fail++; $display("FAIL count_write_read: got %h want 11", rd); end
    repeat (13) @(posedge clk);
    #1;
    n_chk++;
    if (irq0 !== 1'b0 || dut0.r_count !== 32'h20) begin
      n_fail++; $display("FAIL count_write_pre: irq=%b count=%h want 0/20", irq0, dut0.r_count);
    end
    @(posedge clk); #1;
    n_chk++;
    if (irq0 !== 1'b1 || dut0.r_count !== 32'h0) begin
      n_fail++; $display("FAIL count_write_expire: irq=%b count=%h want 1/0", irq0, dut0.r_count);
    end
    wr0(2'd1, 32'h0);
  endtask

  task automatic test_expr_zero();
    wr0(2'd2, 32'd0);
    wr0(2'd3, 32'd0);
    wr0(2'd0, 32'h3);
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (dut0.r_count !== 32'd0 || irq0 !== 1'b1) begin
      n_fail++; $display("FAIL expr_zero: count=%h irq=%b want 0/1", dut0.r_count, irq0);
    end
    wr0(2'd0, 32'h0);
    wr0(2'd1, 32'h0);
    n_chk++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL expr_zero_clear: got %b want 0", irq0); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    int lat;
    bit seen_low;
    bus(1'b1, 1'b1, 2'd2, 32'd0, rd, lat);
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL ws3_latency: got %0d want 4", lat); end
    n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL ws3_read: got %h want 0", rd); end
    cs3_ = 1'b0; as3_ = 1'b0; rw3 = 1'b0; addr3 = 30'd2; wd3 = 32'h55;
    @(posedge clk); #1;
    cs3_ = 1'b1; as3_ = 1'b1;
    @(posedge clk); #1;
    cs3_ = 1'b0; as3_ = 1'b0; wd3 = 32'hAA;
    @(posedge clk); #1;
    cs3_ = 1'b1; as3_ = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (rdy3_ !== 1'b0) begin n_fail++; $display("FAIL ws3_ack: got %b want 0", rdy3_); end
    @(posedge clk); #1;
    bus(1'b1, 1'b1, 2'd2, 32'd0, rd, lat);
    n_chk++; if (rd !== 32'h55) begin n_fail++; $display("FAIL ws3_ignore_strobe: got %h want 55", rd); end
    cs3_ = 1'b0; as3_ = 1'b0; rw3 = 1'b0; addr3 = 30'd2; wd3 = 32'h77;
    @(posedge clk); #1;
    cs3_ = 1'b1; as3_ = 1'b1;
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    n_chk++;
    if (rdy3_ !== 1'b1 || rd3 !== 32'd0 || irq3 !== 1'b0) begin
      n_fail++; $display("FAIL ws3_reset_outputs: rdy_=%b rd=%h irq=%b want 1/0/0", rdy3_, rd3, irq3);
    end
    @(posedge clk); #1;
    rst3_n = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rdy3_ !== 1'b1) seen_low = 1'b1;
      @(posedge clk); #1;
    end
    n_chk++; if (seen_low) begin n_fail++; $display("FAIL ws3_dropped_access: rdy_ went low, want 1"); end
    bus(1'b1, 1'b1, 2'd2, 32'd0, rd, lat);
    n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL ws3_reset_expr: got %h want 0", rd); end
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL ws3_latency_after_reset: got %0d want 4", lat); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_clear_vs_expiry();
    test_count_write();
    test_expr_zero();
    test_wait_states();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
